// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Brief    : Single-outstanding valid/ready controller for a 256Kx16 async
//            SRAM. Optional deselect gap: define SRAM_CTRL_TURNAROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [17:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        sram_cs_n,
  output logic        sram_wr_n,
  output logic        sram_rd_n,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata
);

  localparam logic [3:0] C_CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_HOLD   = 2'd2
`ifdef SRAM_CTRL_TURNAROUND_EN
    ,
    S_TURN   = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] resp_rdata_q, resp_rdata_d;
  logic        cs_n_q, cs_n_d;
  logic        wr_n_q, wr_n_d;
  logic        rd_n_q, rd_n_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_wdata_q, sram_wdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      cs_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      cs_n_q       <= cs_n_d;
      wr_n_q       <= wr_n_d;
      rd_n_q       <= rd_n_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    cs_n_d       = cs_n_q;
    wr_n_d       = wr_n_q;
    rd_n_d       = rd_n_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        cs_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        // req_ready_q gates acceptance so the first idle cycle after reset is dead
        if (req_valid && req_ready_q) begin
          sram_addr_d = req_addr;
          if (req_we) begin
            sram_wdata_d = req_wdata;
          end
          we_d        = req_we;
          cs_n_d      = 1'b0;
          rd_n_d      = req_we;
          wr_n_d      = ~req_we;
          req_ready_d = 1'b0;
          cnt_d       = C_CNT_LOAD;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            resp_rdata_d = sram_rdata;
          end
          rd_n_d       = 1'b1;
          wr_n_d       = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        cs_n_d = 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
        req_ready_d = 1'b0;
        state_d     = S_TURN;
`else
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
`endif
      end
`ifdef SRAM_CTRL_TURNAROUND_EN
      S_TURN: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign sram_cs_n  = cs_n_q;
  assign sram_wr_n  = wr_n_q;
  assign sram_rd_n  = rd_n_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

endmodule
`default_nettype wire
